// File: rtl/float_acc_12_if.sv
// Product stream in / result pulse out bus for the 12-bit float accumulator.
interface float_acc_12_if #(
  parameter int unsigned CNT_W = 10
);
  logic             data_valid_i;
  logic             data_last_i;
  logic [11:0]      data_i;
  logic             acc_valid_o;
  logic [11:0]      acc_data_o;
  logic [CNT_W-1:0] acc_count_o;
  logic             acc_ovf_o;

  modport master (
    output data_valid_i, data_last_i, data_i,
    input  acc_valid_o, acc_data_o, acc_count_o, acc_ovf_o
  );

  modport slave (
    input  data_valid_i, data_last_i, data_i,
    output acc_valid_o, acc_data_o, acc_count_o, acc_ovf_o
  );
endinterface

// File: rtl/float_acc_12.sv
// Streaming 12-bit float accumulator (sign, 5-bit exp bias 15, 6-bit mantissa).
// Sums one valid/last-delimited product stream and emits sum, term count and
// a sticky overflow flag as a one-cycle result pulse.
// Optional macro ACC_RELU_EN: rectify negative final sums to 12'h000 at the
// result register (the running accumulator is never rectified).
module float_acc_12 #(
  parameter int unsigned CNT_W = 10
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  float_acc_12_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [11:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             res_valid;
  logic [11:0]      res_data;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;

  logic [4:0]  exp_x, exp_y, exp_a, exp_b, shift;
  logic [7:0]  sig_x, sig_y, sig_a, sig_b, sig_b_sh, sum8;
  logic [6:0]  diff7;
  logic [10:0] mag_x, mag_y;
  logic        sgn_a, sgn_b;
  logic [2:0]  lz;
  logic [5:0]  exp_inc;
  logic [11:0] sum;
  logic        add_ovf;
  logic [11:0] res_next;
  logic [CNT_W-1:0] cnt_inc;

  // Float adder: sum = acc + data_i with truncating alignment and saturation.
  always_comb begin
    sum      = 12'h000;
    add_ovf  = 1'b0;
    exp_x    = acc[10:6];
    exp_y    = bus.data_i[10:6];
    sig_x    = (exp_x == 5'd0) ? 8'd0 : {2'b01, acc[5:0]};
    sig_y    = (exp_y == 5'd0) ? 8'd0 : {2'b01, bus.data_i[5:0]};
    mag_x    = (exp_x == 5'd0) ? 11'd0 : acc[10:0];
    mag_y    = (exp_y == 5'd0) ? 11'd0 : bus.data_i[10:0];
    if (mag_x >= mag_y) begin
      sgn_a = acc[11];        exp_a = exp_x; sig_a = sig_x;
      sgn_b = bus.data_i[11]; exp_b = exp_y; sig_b = sig_y;
    end else begin
      sgn_a = bus.data_i[11]; exp_a = exp_y; sig_a = sig_y;
      sgn_b = acc[11];        exp_b = exp_x; sig_b = sig_x;
    end
    shift    = exp_a - exp_b;
    sig_b_sh = (shift >= 5'd8) ? 8'd0 : (sig_b >> shift);
    sum8     = sig_a + sig_b_sh;
    diff7    = 7'(sig_a - sig_b_sh);
    lz       = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (diff7[i]) lz = 3'(6 - i);
    end
    exp_inc  = {1'b0, exp_a} + 6'd1;
    if (sgn_a == sgn_b) begin
      if (sum8 == 8'd0) begin
        sum = 12'h000;
      end else if (sum8[7]) begin
        if (exp_inc > 6'd31) begin
          sum     = {sgn_a, 5'd31, 6'h3F};
          add_ovf = 1'b1;
        end else begin
          sum = {sgn_a, exp_inc[4:0], sum8[6:1]};
        end
      end else begin
        sum = {sgn_a, exp_a, sum8[5:0]};
      end
    end else begin
      if (diff7 == 7'd0 || {2'b00, lz} >= exp_a) begin
        sum = 12'h000;
      end else begin
        sum = {sgn_a, exp_a - 5'(lz), 6'(diff7 << lz)};
      end
    end
  end

  // Saturating term count and result-register value.
  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
`ifdef ACC_RELU_EN
    res_next = sum[11] ? 12'h000 : sum;
`else
    res_next = sum;
`endif
  end

  // Accumulator, counter, sticky flag and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc       <= 12'h000;
      cnt       <= '0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 12'h000;
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (bus.data_valid_i) begin
        if (bus.data_last_i) begin
          res_valid <= 1'b1;
          res_data  <= res_next;
          res_count <= cnt_inc;
          res_ovf   <= ovf | add_ovf;
          acc       <= 12'h000;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= sum;
          cnt <= cnt_inc;
          ovf <= ovf | add_ovf;
        end
      end
    end
  end

  assign bus.acc_valid_o = res_valid;
  assign bus.acc_data_o  = res_data;
  assign bus.acc_count_o = res_count;
  assign bus.acc_ovf_o   = res_ovf;

endmodule

// File: tb/tb_float_acc_12.sv
// Self-checking bench for float_acc_12: directed cases plus random streams
// compared against an integer-arithmetic float model.
module tb_float_acc_12;

  localparam int unsigned CNT_W = 10;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  float_acc_12_if #(.CNT_W(CNT_W)) bus ();

  float_acc_12 #(.CNT_W(CNT_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: running stream and expected held result outputs
  logic [11:0] m_acc = 12'h000;
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic [11:0] e_data = 12'h000;
  int          e_cnt  = 0;
  logic        e_ovf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference add: decode to integer significands, align, add, renormalise.
  function automatic void fadd(input logic [11:0] x, input logic [11:0] y,
                               output logic [11:0] r, output logic o);
    int ex, ey, mx, my, kx, ky, ea, eb, ma, mb, s, e, sh;
    logic sa, sb;
    ex = int'(x[10:6]); ey = int'(y[10:6]);
    mx = (ex == 0) ? 0 : 64 + int'(x[5:0]);
    my = (ey == 0) ? 0 : 64 + int'(y[5:0]);
    kx = (ex == 0) ? 0 : int'(x[10:0]);
    ky = (ey == 0) ? 0 : int'(y[10:0]);
    if (kx >= ky) begin
      sa = x[11]; ea = ex; ma = mx; sb = y[11]; eb = ey; mb = my;
    end else begin
      sa = y[11]; ea = ey; ma = my; sb = x[11]; eb = ex; mb = mx;
    end
    sh = ea - eb;
    mb = (sh >= 8) ? 0 : (mb >> sh);
    s  = (sa == sb) ? ma + mb : ma - mb;
    e  = ea;
    o  = 1'b0;
    r  = 12'h000;
    if (s != 0) begin
      while (s >= 128) begin s = s / 2; e++; end
      while (s < 64)   begin s = s * 2; e--; end
      if (e > 31) begin
        r = {sa, 5'd31, 6'h3F};
        o = 1'b1;
      end else if (e > 0) begin
        r = {sa, 5'(e), 6'(s - 64)};
      end
    end
  endfunction

  function automatic logic [11:0] relu(input logic [11:0] s);
`ifdef ACC_RELU_EN
    return s[11] ? 12'h000 : s;
`else
    return s;
`endif
  endfunction

  task automatic check_outputs(input logic pulse);
    check("valid", 32'(bus.acc_valid_o), 32'(pulse));
    check("data",  32'(bus.acc_data_o),  32'(e_data));
    check("count", 32'(bus.acc_count_o), 32'(e_cnt));
    check("ovf",   32'(bus.acc_ovf_o),   32'(e_ovf));
  endtask

  // One clock of stimulus; model updates at the same edge, outputs checked #1 later.
  task automatic send(input logic v, input logic l, input logic [11:0] d);
    logic [11:0] s;
    logic        o;
    int          nc;
    @(negedge clk);
    rst_n = 1'b1;
    bus.data_valid_i = v;
    bus.data_last_i  = l;
    bus.data_i       = d;
    @(posedge clk);
    fadd(m_acc, d, s, o);
    if (v) begin
      nc = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
      if (l) begin
        e_data = relu(s); e_cnt = nc; e_ovf = m_ovf | o;
        m_acc = 12'h000; m_cnt = 0; m_ovf = 1'b0;
      end else begin
        m_acc = s; m_cnt = nc; m_ovf = m_ovf | o;
      end
    end
    #1;
    check_outputs(v && l);
  endtask

  // Reset with a simultaneous valid/last product: reset must win.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.data_valid_i = 1'b1;
    bus.data_last_i  = 1'b1;
    bus.data_i       = 12'h3C0;
    @(posedge clk);
    m_acc = 12'h000; m_cnt = 0; m_ovf = 1'b0;
    e_data = 12'h000; e_cnt = 0; e_ovf = 1'b0;
    #1;
    check_outputs(1'b0);
  endtask

  initial begin
    logic [11:0] d;
    int len;
    rst_n = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.data_last_i  = 1'b0;
    bus.data_i       = 12'h000;
    do_reset();
    do_reset();

    // 1.0 + 1.5 = 2.5
    send(1'b1, 1'b0, 12'h3C0);
    send(1'b1, 1'b1, 12'h3E0);
    check("sum_2p5", 32'(bus.acc_data_o), 32'h410);
    check("cnt_2",   32'(bus.acc_count_o), 32'd2);
    send(1'b0, 1'b0, 12'h000);

    // exact cancellation, then back-to-back single-term stream
    send(1'b1, 1'b0, 12'h3C0);
    send(1'b1, 1'b1, 12'hBC0);
    check("cancel", 32'(bus.acc_data_o), 32'h000);
    send(1'b1, 1'b1, 12'h380);
    check("b2b", 32'(bus.acc_data_o), 32'h380);
    check("b2b_cnt", 32'(bus.acc_count_o), 32'd1);

    // saturation sets ovf; next stream starts clean
    send(1'b1, 1'b0, 12'h7FF);
    send(1'b1, 1'b1, 12'h7FF);
    check("sat", 32'(bus.acc_data_o), 32'h7FF);
    check("sat_ovf", 32'(bus.acc_ovf_o), 32'd1);
    send(1'b1, 1'b1, 12'h3C0);
    check("ovf_clear", 32'(bus.acc_ovf_o), 32'd0);

    // idle gaps, zero-exponent operand, last ignored without valid
    send(1'b1, 1'b0, 12'h400);
    send(1'b0, 1'b1, 12'h3C0);
    send(1'b0, 1'b0, 12'h3C0);
    send(1'b0, 1'b1, 12'h7FF);
    send(1'b1, 1'b0, 12'h03F);
    send(1'b1, 1'b1, 12'h380);
    check("gap_sum", 32'(bus.acc_data_o), 32'h410);
    check("gap_cnt", 32'(bus.acc_count_o), 32'd3);

    // reset discards a stream in progress
    send(1'b1, 1'b0, 12'h3C0);
    send(1'b1, 1'b0, 12'h3C0);
    do_reset();
    send(1'b1, 1'b1, 12'h380);
    check("post_rst", 32'(bus.acc_data_o), 32'h380);
    check("post_rst_cnt", 32'(bus.acc_count_o), 32'd1);

    // single zero-exponent term and a negative single term
    send(1'b1, 1'b1, 12'h83F);
    check("zero_term", 32'(bus.acc_data_o), 32'h000);
    send(1'b1, 1'b1, 12'hBC0);
`ifdef ACC_RELU_EN
    check("neg_term", 32'(bus.acc_data_o), 32'h000);
`else
    check("neg_term", 32'(bus.acc_data_o), 32'hBC0);
`endif

    // counter saturation
    for (int i = 0; i < MAXC + 6; i++) send(1'b1, 1'b0, 12'h000);
    send(1'b1, 1'b1, 12'h000);
    check("cnt_sat", 32'(bus.acc_count_o), 32'(MAXC));

    // random streams with gaps, cancellations and large exponents
    for (int n = 0; n < 60; n++) begin
      len = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 7))
          0: d = m_acc ^ 12'h800;
          1: d = {1'($urandom), 5'($urandom_range(29, 31)), 6'($urandom)};
          2: d = {1'($urandom), 5'($urandom_range(0, 2)), 6'($urandom)};
          default: d = 12'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) send(1'b0, 1'($urandom), 12'($urandom));
        send(1'b1, (k == len - 1), d);
      end
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_acc_12.md
Name: float_acc_12

Overview:
- Streaming 12-bit float accumulator directly downstream of the 12-bit float multiplier in the neuron datapath.
- Consumes one product per cycle with a valid/last strobe and sums the products of one dot-product stream.
- Emits the final sum, the term count and an overflow flag as a single-cycle result pulse.
- Operand format is the same as the multiplier output: [11] sign, [10:6] exponent with bias 15, [5:0] mantissa with hidden 1.

Parameters:
CNT_W, 10, width of the term counter; the counter saturates at 2^CNT_W-1.

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_n_i  in  1  reset, synchronous, active-low
data_valid_i  in  1  data_i carries a product this cycle
data_last_i  in  1  final product of the current stream; qualified by data_valid_i
data_i  in  12  product from the multiplier
acc_valid_o  out  1  one-cycle pulse; the result outputs are valid
acc_data_o  out  12  accumulated sum
acc_count_o  out  CNT_W  number of valid terms in the completed stream
acc_ovf_o  out  1  sticky per stream; set if any add saturated

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - Internal accumulator, term counter and overflow flag clear to 0.
  - acc_valid_o=0, acc_data_o=0, acc_count_o=0, acc_ovf_o=0.
  - Reset wins over any simultaneous data_valid_i. A stream in progress is discarded and no result pulse is produced.
- Zero encoding:
  - Any operand with exponent==0 is treated as zero, whatever its mantissa.
  - The accumulator idles at 12'h000.
- Add datapath (combinational, accumulator feedback; sum = acc + data_i):
  - Expand both operands to 8-bit significands {0,1,man}.
  - Swap so A has the larger magnitude (compare exp, then man).
  - Right-shift B by (expA-expB). Truncate the shifted-out bits; a shift of 8 or more gives 0.
  - Equal signs: add. Carry out increments the exponent and shifts right by 1 (truncate).
  - Unequal signs: subtract B from A, then normalize with a leading-one detect, shifting left and subtracting from the exponent.
  - Exact cancellation gives +0 (12'h000).
  - Exponent underflow (normalized exp <= 0) gives +0.
  - Exponent overflow (exp > 31) saturates to {sign,5'd31,6'h3F} and sets the overflow flag.
  - An operand already at exp 31 is used as-is; there is no infinity/NaN handling.
  - Result sign is the sign of A.
- Cycle behaviour, with data_valid_i=1 sampled at edge N:
  - Accumulator updates at edge N: acc <= add(acc, data_i).
  - Counter increments and saturates at its maximum.
  - If data_last_i=1 as well:
    - At the same edge, acc_data_o <= add(acc, data_i), acc_count_o <= count+1 (saturated), acc_ovf_o <= ovf | ovf_this_add.
    - acc_valid_o pulses for the cycle following edge N (latency 1).
    - At the same edge, accumulator, counter and overflow flag clear, so the next stream may start on the very next cycle with no bubble.
- data_valid_i=0: no state change; acc_valid_o deasserts after one cycle.
- data_last_i with data_valid_i=0 is ignored.
- Result outputs hold their last value until the next pulse; only acc_valid_o returns to 0.
- Single-term stream (valid+last in the first cycle): the result is data_i normalized; a zero-exponent input gives 12'h000 with count 1.

Optional Feature:
ACC_RELU_EN
- Defined: ReLU is applied at the result register. If the final sum is negative, acc_data_o <= 12'h000; acc_count_o and acc_ovf_o are unaffected. The internal accumulator is never rectified.
- Undefined: acc_data_o is the signed sum.

Test Plan:
- Stream 12'h3C0 (1.0), then 12'h3E0 (1.5) with last → acc_valid_o pulses once, one cycle after the last edge; acc_data_o=12'h410 (2.5); acc_count_o=2; acc_ovf_o=0.
- Stream 12'h3C0, then 12'hBC0 (-1.0) with last → acc_data_o=12'h000, count 2; the next stream 12'h380 (0.5) with last, sent on the following cycle, gives 12'h380, count 1.
- Stream 12'h7FF, then 12'h7FF with last → acc_data_o=12'h7FF; acc_ovf_o=1; the next stream starts with ovf=0.
- Stream 12'h400 (2.0), idle 3 cycles, 12'h03F (exponent 0, treated as zero), then 12'h380 with last → 12'h410 (2.5), count 3.
- Stream 12'h3C0, 12'h3C0, then rst_n_i=0 for 1 cycle, then 12'h380 with last → no pulse before reset; result 12'h380, count 1.
- Built with ACC_RELU_EN: stream 12'hBC0 with last → 12'h000, count 1. Built without it, the same stream gives 12'hBC0.
